// File: rtl/usb_arb_pkg.sv
// Shared definitions for the USB IN byte-path arbiter: state encoding,
// byte width and the packet byte-count width helper.
package usb_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // Counter must be able to hold MAX_PKT itself.
  function automatic int cnt_width(input int max_pkt);
    return $clog2(max_pkt + 1);
  endfunction

endpackage

// File: rtl/usb_in_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr,
// wrapping around to index 0.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx,
  output logic             any
);

  always_comb begin
    int j;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j[IW-1:0]]) begin
        any              = 1'b1;
        win[j[IW-1:0]]   = 1'b1;
        win_idx          = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/usb_in_arbiter.sv
// Packet-level round-robin arbiter feeding the USB core IN byte path,
// one byte per data_strobe, one requester per packet.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// LOAD  | owner granted; pop its next byte when available
// WAIT  | byte presented to the core; wait for data_strobe
// GAP   | packet ended; release grant, advance rr pointer
module usb_in_arbiter
  import usb_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int MAX_PKT = 64
) (
  input  logic                      clk48,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]         data_in,
  output logic                      data_in_valid,
  input  logic                      data_strobe,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      pkt_trunc
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_width(MAX_PKT);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       cnt_inc;
  logic                last_q, last_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                trunc_q, trunc_d;

  logic [N_REQ-1:0]    pick_win;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    count_d = count_q;
    last_d  = last_q;
    grant_d = grant_q;
    ready_d = '0;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    trunc_d = 1'b0;
    cnt_inc = count_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          gidx_d  = pick_idx;
          count_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[gidx_q]) begin
          data_d          = req_data[BYTE_W*int'(gidx_q) +: BYTE_W];
          valid_d         = 1'b1;
          ready_d[gidx_q] = 1'b1;
          last_d          = req_last[gidx_q];
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (data_strobe) begin
          valid_d = 1'b0;
          count_d = cnt_inc;
          // A genuine last byte takes precedence over the length limit.
          if (last_q) begin
            done_d  = 1'b1;
            state_d = GAP;
          end else if (cnt_inc == CW'(MAX_PKT)) begin
            trunc_d = 1'b1;
            state_d = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        grant_d = '0;
        ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      count_q <= count_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
    end
  end

  assign req_ready     = ready_q;
  assign data_in       = data_q;
  assign data_in_valid = valid_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign pkt_done      = done_q;
  assign pkt_trunc     = trunc_q;

endmodule
